// File: rtl/hb_xcel_pkg.sv
// Shared definitions for the block-sum accelerator: CSR indices, FSM states and master request types.
package hb_xcel_pkg;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_SRC    = 3'd1;
    localparam logic [2:0] CSR_DST    = 3'd2;
    localparam logic [2:0] CSR_SIZE   = 3'd3;
    localparam logic [2:0] CSR_RESULT = 3'd4;
    localparam logic [2:0] CSR_CYCLES = 3'd5;

    localparam logic MASTER_LOAD  = 1'b0;
    localparam logic MASTER_STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        STORE = 2'd3
    } xcel_state_e;

endpackage

// File: rtl/hb_xcel_csr_file.sv
// CSR block: byte-masked configuration writes, read mux and a one-cycle registered slave response.
module hb_xcel_csr_file
    import hb_xcel_pkg::*;
#(
    parameter int data_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [2:0]                idx,
    input  logic [data_width_p-1:0]   wdata,
    input  logic [data_width_p/8-1:0] mask,
    input  logic                      wr,
    input  logic                      val,
    input  logic                      busy,
    input  logic                      done,
    input  logic [data_width_p-1:0]   result,
    input  logic [data_width_p-1:0]   cycles,
    output logic                      go,
    output logic [data_width_p-1:0]   src,
    output logic [data_width_p-1:0]   dst,
    output logic [data_width_p-1:0]   size,
    output logic [data_width_p-1:0]   ret_data,
    output logic                      ret_val
);

    localparam int LANES = data_width_p / 8;

    logic [data_width_p-1:0] src_reg, dst_reg, size_reg;
    logic [data_width_p-1:0] src_next, dst_next, size_next;
    logic [data_width_p-1:0] rd_data, ret_data_reg;
    logic                    ret_val_reg;
    logic                    cfg_wr;

    // Configuration is frozen while a run is in flight, including a second GO.
    assign cfg_wr = val && wr && !busy;
    assign go     = cfg_wr && (idx == CSR_CTRL) && mask[0] && wdata[0];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign src_next[gi*8 +: 8]  = (cfg_wr && (idx == CSR_SRC) && mask[gi])
                                          ? wdata[gi*8 +: 8] : src_reg[gi*8 +: 8];
            assign dst_next[gi*8 +: 8]  = (cfg_wr && (idx == CSR_DST) && mask[gi])
                                          ? wdata[gi*8 +: 8] : dst_reg[gi*8 +: 8];
            assign size_next[gi*8 +: 8] = (cfg_wr && (idx == CSR_SIZE) && mask[gi])
                                          ? wdata[gi*8 +: 8] : size_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (idx)
            CSR_CTRL:   rd_data = {{(data_width_p-2){1'b0}}, done, busy};
            CSR_SRC:    rd_data = src_reg;
            CSR_DST:    rd_data = dst_reg;
            CSR_SIZE:   rd_data = size_reg;
            CSR_RESULT: rd_data = result;
            CSR_CYCLES: rd_data = cycles;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            src_reg      <= '0;
            dst_reg      <= '0;
            size_reg     <= '0;
            ret_val_reg  <= 1'b0;
            ret_data_reg <= '0;
        end else begin
            src_reg      <= src_next;
            dst_reg      <= dst_next;
            size_reg     <= size_next;
            ret_val_reg  <= val;
            ret_data_reg <= (val && !wr) ? rd_data : '0;
        end
    end

    assign src      = src_reg;
    assign dst      = dst_reg;
    assign size     = size_reg;
    assign ret_data = ret_data_reg;
    assign ret_val  = ret_val_reg;

endmodule

// File: rtl/hb_ifc_mem_xcel.sv
// Block-sum accelerator: loads SIZE words from SRC, stores their sum to DST, then flags done.
// Optional HB_XCEL_PERF_CNT_EN adds a run-cycle counter readable at CSR 5.
module hb_ifc_mem_xcel
    import hb_xcel_pkg::*;
#(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int load_id_width_p   = 11,
    parameter int max_outstanding_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [addr_width_p-1:0]    slave_addr,
    input  logic [data_width_p-1:0]    slave_data,
    input  logic [data_width_p/8-1:0]  slave_mask,
    input  logic                       slave_type,
    input  logic                       slave_val,
    output logic                       slave_yum,
    output logic [data_width_p-1:0]    slave_ret_data,
    output logic                       slave_ret_val,
    output logic                       master_val,
    output logic                       master_type,
    output logic [31:0]                master_addr,
    output logic [load_id_width_p-1:0] master_opq,
    output logic [data_width_p-1:0]    master_data,
    output logic [data_width_p/8-1:0]  master_mask,
    input  logic                       master_rdy,
    input  logic [data_width_p-1:0]    master_ret_data,
    input  logic [load_id_width_p-1:0] master_ret_opq,
    input  logic                       master_ret_val
);

    localparam int OUT_W = $clog2(max_outstanding_p + 1);

    xcel_state_e             state_reg, state_next;
    logic [data_width_p-1:0] src, dst, size, cycles;
    logic [data_width_p-1:0] result_reg, issued_reg, returns_reg;
    logic [OUT_W-1:0]        outstanding_reg;
    logic                    done_reg, go, busy;
    logic                    can_issue, issue, ret_ok, store_fire;
    logic                    unused_inputs;

    // Returns are matched by count, not by id; the upper address bits alias onto the CSR window.
    assign unused_inputs = ^{slave_addr[addr_width_p-1:3], master_ret_opq};

    assign slave_yum  = slave_val;
    assign busy       = (state_reg != IDLE);
    assign can_issue  = (issued_reg < size) && (outstanding_reg < OUT_W'(max_outstanding_p));
    assign issue      = (state_reg == LOAD) && can_issue && master_rdy;
    assign ret_ok     = master_ret_val && (outstanding_reg != '0);
    assign store_fire = (state_reg == STORE) && master_rdy;

    hb_xcel_csr_file #(
        .data_width_p(data_width_p)
    ) u_csr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .idx      (slave_addr[2:0]),
        .wdata    (slave_data),
        .mask     (slave_mask),
        .wr       (slave_type),
        .val      (slave_val),
        .busy     (busy),
        .done     (done_reg),
        .result   (result_reg),
        .cycles   (cycles),
        .go       (go),
        .src      (src),
        .dst      (dst),
        .size     (size),
        .ret_data (slave_ret_data),
        .ret_val  (slave_ret_val)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (go) state_next = (size == '0) ? STORE : LOAD;
            LOAD:  if (issued_reg == size) state_next = DRAIN;
            DRAIN: if ((outstanding_reg == '0) && (returns_reg == size)) state_next = STORE;
            STORE: if (master_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        master_val  = 1'b0;
        master_type = MASTER_LOAD;
        master_addr = '0;
        master_opq  = '0;
        master_data = '0;
        master_mask = '0;
        case (state_reg)
            LOAD: begin
                master_val  = can_issue;
                master_addr = 32'(src + (issued_reg << 2));
                master_opq  = load_id_width_p'(issued_reg);
                master_mask = '1;
            end
            STORE: begin
                master_val  = 1'b1;
                master_type = MASTER_STORE;
                master_addr = 32'(dst);
                master_data = result_reg;
                master_mask = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            issued_reg      <= '0;
            returns_reg     <= '0;
            outstanding_reg <= '0;
            result_reg      <= '0;
            done_reg        <= 1'b0;
        end else if (go) begin
            issued_reg      <= '0;
            returns_reg     <= '0;
            outstanding_reg <= '0;
            result_reg      <= '0;
            done_reg        <= 1'b0;
        end else begin
            if (issue) begin
                issued_reg <= issued_reg + data_width_p'(1);
            end
            if (ret_ok) begin
                returns_reg <= returns_reg + data_width_p'(1);
                result_reg  <= result_reg + master_ret_data;
            end
            // A return in the same cycle as an issue leaves the in-flight count unchanged.
            if (issue && !ret_ok) begin
                outstanding_reg <= outstanding_reg + OUT_W'(1);
            end else if (!issue && ret_ok) begin
                outstanding_reg <= outstanding_reg - OUT_W'(1);
            end
            if (store_fire) begin
                done_reg <= 1'b1;
            end
        end
    end

`ifdef HB_XCEL_PERF_CNT_EN
    logic [data_width_p-1:0] cycles_reg;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cycles_reg <= '0;
        end else if (go) begin
            cycles_reg <= '0;
        end else if (busy) begin
            cycles_reg <= cycles_reg + data_width_p'(1);
        end
    end

    assign cycles = cycles_reg;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_hb_ifc_mem_xcel.sv
// Scoreboard bench for hb_ifc_mem_xcel: directed CSR programming, a memory responder and request/response monitors.
module tb_hb_ifc_mem_xcel;

    typedef struct {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic [10:0] opq;
    } mreq_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } srsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [10:0] opq;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] slave_addr;
    logic [31:0] slave_data;
    logic [3:0]  slave_mask;
    logic        slave_type;
    logic        slave_val;
    logic        slave_yum;
    logic [31:0] slave_ret_data;
    logic        slave_ret_val;
    logic        master_val;
    logic        master_type;
    logic [31:0] master_addr;
    logic [10:0] master_opq;
    logic [31:0] master_data;
    logic [3:0]  master_mask;
    logic        master_rdy;
    logic [31:0] master_ret_data;
    logic [10:0] master_ret_opq;
    logic        master_ret_val;

    mreq_t       exp_master[$];
    srsp_t       exp_slave[$];
    pend_t       pending[$];
    logic [31:0] mem [logic [31:0]];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_load = 0;
    int   n_store = 0;
    int   n_ret = 0;
    int   max_inflight = 0;
    logic rdy_en = 1'b1;
    logic ret_en = 1'b1;
    logic ooo = 1'b0;

    assign master_rdy = rdy_en;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hb_ifc_mem_xcel #(
        .data_width_p      (32),
        .addr_width_p      (32),
        .load_id_width_p   (11),
        .max_outstanding_p (2)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .slave_addr      (slave_addr),
        .slave_data      (slave_data),
        .slave_mask      (slave_mask),
        .slave_type      (slave_type),
        .slave_val       (slave_val),
        .slave_yum       (slave_yum),
        .slave_ret_data  (slave_ret_data),
        .slave_ret_val   (slave_ret_val),
        .master_val      (master_val),
        .master_type     (master_type),
        .master_addr     (master_addr),
        .master_opq      (master_opq),
        .master_data     (master_data),
        .master_mask     (master_mask),
        .master_rdy      (master_rdy),
        .master_ret_data (master_ret_data),
        .master_ret_opq  (master_ret_opq),
        .master_ret_val  (master_ret_val)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Slave response monitor
    initial begin
        srsp_t e;
        forever begin
            @(negedge clk);
            if (slave_ret_val === 1'b1) begin
                if (exp_slave.size() == 0) begin
                    chk("slave_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_slave.pop_front();
                    $display("slave rsp   data=%h cyc=%0d", slave_ret_data, cyc);
                    chk("slave_rsp_data", slave_ret_data, e.data);
                    chk("slave_rsp_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Memory responder and master request monitor
    initial begin
        mreq_t       e;
        pend_t       p;
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [31:0] prev_data;
        master_ret_val  = 1'b0;
        master_ret_data = '0;
        master_ret_opq  = '0;
        prev_stall      = 1'b0;
        prev_addr       = '0;
        prev_data       = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && reset_i) begin
                chk("req_held_val", {31'b0, master_val}, 32'd1);
                chk("req_held_addr", master_addr, prev_addr);
                chk("req_held_data", master_data, prev_data);
            end
            prev_stall = reset_i && master_val && !master_rdy;
            prev_addr  = master_addr;
            prev_data  = master_data;
            // Choose the return before recording this cycle's issue so returns lag issues by >=1 cycle.
            if (reset_i && ret_en && pending.size() > 0) begin
                p = ooo ? pending.pop_back() : pending.pop_front();
                master_ret_val  = 1'b1;
                master_ret_data = mem_rd(p.addr);
                master_ret_opq  = p.opq;
                n_ret++;
            end else begin
                master_ret_val  = 1'b0;
                master_ret_data = '0;
                master_ret_opq  = '0;
            end
            if (reset_i && master_val && master_rdy) begin
                $display("master req  type=%0d addr=%h data=%h opq=%0d", master_type, master_addr,
                         master_data, master_opq);
                if (exp_master.size() == 0) begin
                    chk("master_unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = exp_master.pop_front();
                    chk("master_type", {31'b0, master_type}, {31'b0, e.typ});
                    chk("master_addr", master_addr, e.addr);
                    chk("master_data", master_data, e.data);
                    chk("master_mask", {28'b0, master_mask}, 32'hF);
                    if (e.typ == 1'b0) chk("master_opq", {21'b0, master_opq}, {21'b0, e.opq});
                end
                if (master_type == 1'b0) begin
                    pending.push_back('{addr: master_addr, opq: master_opq});
                    n_load++;
                end else begin
                    n_store++;
                end
            end
            if (n_load - n_ret > max_inflight) max_inflight = n_load - n_ret;
        end
    end

    task automatic slave_xact(input logic wr, input logic [2:0] idx, input logic [31:0] d,
                              input logic [3:0] m, input logic [31:0] expv);
        @(posedge clk);
        #1;
        slave_val  = 1'b1;
        slave_type = wr;
        slave_addr = {29'b0, idx};
        slave_data = d;
        slave_mask = m;
        exp_slave.push_back('{data: (wr ? 32'h0 : expv), cyc: cyc + 1});
        @(negedge clk);
        chk("slave_yum", {31'b0, slave_yum}, 32'd1);
        @(posedge clk);
        #1;
        slave_val  = 1'b0;
        slave_type = 1'b0;
        slave_data = '0;
        slave_mask = '0;
    endtask

    task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] m);
        slave_xact(1'b1, idx, d, m, 32'h0);
    endtask

    task automatic csr_rd(input logic [2:0] idx, input logic [31:0] expv);
        slave_xact(1'b0, idx, 32'h0, 4'h0, expv);
    endtask

    task automatic expect_run(input logic [31:0] src, input logic [31:0] dst, input int n,
                              input logic with_store);
        logic [31:0] sum;
        sum = 32'h0;
        for (int i = 0; i < n; i++) begin
            exp_master.push_back('{typ: 1'b0, addr: src + 32'(4 * i), data: 32'h0, opq: 11'(i)});
            sum = sum + mem_rd(src + 32'(4 * i));
        end
        if (with_store) exp_master.push_back('{typ: 1'b1, addr: dst, data: sum, opq: 11'h0});
    endtask

    task automatic wait_loads(input int target);
        for (int k = 0; k < 400 && n_load < target; k++) @(posedge clk);
        chk("wait_loads", {31'b0, (n_load >= target)}, 32'd1);
    endtask

    task automatic wait_stores(input int target);
        for (int k = 0; k < 400 && n_store < target; k++) @(posedge clk);
        chk("wait_stores", {31'b0, (n_store >= target)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_i    = 1'b0;
        slave_val  = 1'b0;
        slave_type = 1'b0;
        slave_addr = '0;
        slave_data = '0;
        slave_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_master_val", {31'b0, master_val}, 32'd0);
        chk("rst_master_addr", master_addr, 32'd0);
        chk("rst_master_mask", {28'b0, master_mask}, 32'd0);
        chk("rst_slave_ret_val", {31'b0, slave_ret_val}, 32'd0);
        reset_i = 1'b1;
        csr_rd(3'd0, 32'h0);
        csr_rd(3'd4, 32'h0);
        csr_rd(3'd3, 32'h0);

        // CSR access, byte masks, unmapped indices
        csr_wr(3'd1, 32'h100, 4'hF);
        csr_rd(3'd1, 32'h100);
        csr_wr(3'd2, 32'hAABBCCDD, 4'b0101);
        csr_rd(3'd2, 32'h00BB00DD);
        csr_wr(3'd6, 32'h12345678, 4'hF);
        csr_rd(3'd6, 32'h0);
        csr_rd(3'd5, 32'h0);

        // Basic four-word sum
        mem[32'h1000] = 32'd1;
        mem[32'h1004] = 32'd2;
        mem[32'h1008] = 32'd3;
        mem[32'h100C] = 32'd4;
        expect_run(32'h1000, 32'h2000, 4, 1'b1);
        csr_wr(3'd1, 32'h1000, 4'hF);
        csr_wr(3'd2, 32'h2000, 4'hF);
        csr_wr(3'd3, 32'd4, 4'hF);
        csr_wr(3'd0, 32'd1, 4'hF);
        wait_stores(1);
        csr_rd(3'd0, 32'h2);
        csr_rd(3'd4, 32'd10);

        // Outstanding limit, busy-time writes ignored, rdy stall
        mem[32'h3000] = 32'd5;
        mem[32'h3004] = 32'd6;
        mem[32'h3008] = 32'd7;
        mem[32'h300C] = 32'd8;
        ret_en = 1'b0;
        base = n_load;
        expect_run(32'h3000, 32'h4000, 4, 1'b1);
        csr_wr(3'd1, 32'h3000, 4'hF);
        csr_wr(3'd2, 32'h4000, 4'hF);
        csr_wr(3'd0, 32'd1, 4'hF);
        wait_loads(base + 2);
        repeat (5) @(posedge clk);
        chk("outstanding_limit", 32'(n_load), 32'(base + 2));
        csr_wr(3'd1, 32'hDEAD0000, 4'hF);
        csr_wr(3'd0, 32'd1, 4'hF);
        csr_rd(3'd1, 32'h3000);
        csr_rd(3'd0, 32'h1);
        @(posedge clk);
        #1;
        ret_en = 1'b1;
        rdy_en = 1'b0;
        repeat (5) @(posedge clk);
        chk("stall_no_issue", 32'(n_load), 32'(base + 2));
        #1;
        rdy_en = 1'b1;
        wait_stores(2);
        csr_rd(3'd4, 32'd26);
        csr_rd(3'd0, 32'h2);
        chk("max_inflight", {31'b0, (max_inflight <= 2)}, 32'd1);

        // Out-of-order returns with 32-bit wrap
        mem[32'h5000] = 32'hFFFFFFFF;
        mem[32'h5004] = 32'd2;
        ret_en = 1'b0;
        ooo = 1'b1;
        base = n_load;
        expect_run(32'h5000, 32'h6000, 2, 1'b1);
        csr_wr(3'd1, 32'h5000, 4'hF);
        csr_wr(3'd2, 32'h6000, 4'hF);
        csr_wr(3'd3, 32'd2, 4'hF);
        csr_wr(3'd0, 32'd1, 4'hF);
        wait_loads(base + 2);
        @(posedge clk);
        #1;
        ret_en = 1'b1;
        wait_stores(3);
        ooo = 1'b0;
        csr_rd(3'd4, 32'd1);
        csr_rd(3'd0, 32'h2);

        // Zero-length run
        expect_run(32'h5000, 32'h7000, 0, 1'b1);
        csr_wr(3'd3, 32'd0, 4'hF);
        csr_wr(3'd2, 32'h7000, 4'hF);
        csr_wr(3'd0, 32'd1, 4'hF);
        wait_stores(4);
        csr_rd(3'd0, 32'h2);
        csr_rd(3'd4, 32'h0);

        // Reset mid-LOAD with loads still in flight
        ret_en = 1'b0;
        base = n_load;
        expect_run(32'h1000, 32'h2000, 2, 1'b0);
        csr_wr(3'd1, 32'h1000, 4'hF);
        csr_wr(3'd2, 32'h2000, 4'hF);
        csr_wr(3'd3, 32'd4, 4'hF);
        csr_wr(3'd0, 32'd1, 4'hF);
        wait_loads(base + 2);
        @(posedge clk);
        #2;
        reset_i = 1'b0;
        #1;
        chk("abort_master_val", {31'b0, master_val}, 32'd0);
        chk("abort_master_addr", master_addr, 32'd0);
        chk("abort_master_mask", {28'b0, master_mask}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b1;
        ret_en = 1'b1;
        repeat (6) @(posedge clk);
        chk("abort_no_new_loads", 32'(n_load), 32'(base + 2));
        csr_rd(3'd4, 32'h0);
        csr_rd(3'd0, 32'h0);
        csr_rd(3'd1, 32'h0);

        repeat (5) @(posedge clk);
        chk("master_queue_drained", 32'(exp_master.size()), 32'd0);
        chk("slave_queue_drained", 32'(exp_slave.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
